// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/forwarding controller for an N-stage in-order pipeline.
//   Tracks in-flight destination tags, issues per-operand forward selects, load-use
//   stalls, flush, and a halt drain FSM.
//   Optional feature macro: STALL_COUNT_EN (adds a saturating stall cycle counter).
// Ports:
//   clk          pipeline clock
//   rst          asynchronous, active-low reset
//   issue_valid  decode presents an instruction
//   issue_wr     instruction writes issue_rd
//   issue_rd     destination register
//   issue_load   result comes from memory
//   issue_halt   halt instruction
//   src_used     operand i is read
//   src_addr     operand i address, slice i
//   flush        kill all in-flight entries
//   issue_accept instruction enters stage 1 next edge
//   stall        hold decode/fetch this cycle
//   fwd_sel      per operand: 0 = register file, k = result of stage k
//   halt_sys     pipeline halted (registered, sticky until reset)
//   busy         any stage entry valid
//   stall_cnt    (STALL_COUNT_EN only) saturating count of RUN-state stall cycles
module pipe_hazard_ctrl #(
    parameter int STAGES     = 3,
    parameter int REG_AW     = 4,
    parameter int NSRC       = 2,
    parameter int LOAD_STAGE = 3,
    localparam int SELW      = $clog2(STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic                   issue_wr,
    input  logic [REG_AW-1:0]      issue_rd,
    input  logic                   issue_load,
    input  logic                   issue_halt,
    input  logic [NSRC-1:0]        src_used,
    input  logic [NSRC*REG_AW-1:0] src_addr,
    input  logic                   flush,
    output logic                   issue_accept,
    output logic                   stall,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   halt_sys,
    output logic                   busy
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t state, state_nxt;
    logic [STAGES:1] v, v_nxt, w, ld;
    logic [REG_AW-1:0] rd [1:STAGES];
    logic [SELW-1:0] s;
    logic h;
    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_sel = '0;
        stall = 1'b0;
        s = '0;
        h = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            s = '0;
            h = 1'b0;
            for (int k = STAGES; k >= 1; k--) begin
                if (v[k] && w[k] && src_used[i] && rd[k] == src_addr[i*REG_AW +: REG_AW]) begin
                    s = SELW'(k);
                    h = ld[k] && (k < LOAD_STAGE);
                end
            end
            fwd_sel[i*SELW +: SELW] = flush ? '0 : s;
            stall = stall | (issue_valid & ~flush & h);
        end
    end
    assign issue_accept = issue_valid & ~stall & (state == RUN);
    // A same-cycle accepted issue survives a flush: it is younger than the redirect.
    assign v_nxt = {(flush ? {(STAGES-1){1'b0}} : v[STAGES-1:1]), issue_accept};
    assign state_nxt = (state == RUN && issue_accept && issue_halt) ? DRAIN :
                       (state == DRAIN && (flush || v_nxt == '0)) ? HALTED : state;
    assign halt_sys = (state == HALTED);
    assign busy = |v;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= '0;
            state <= RUN;
        end else begin
            v <= v_nxt;
            state <= state_nxt;
        end
    end
    // Payload needs no reset: it is only ever qualified by v.
    always_ff @(posedge clk) begin
        w <= {w[STAGES-1:1], issue_wr & ~issue_halt};
        ld <= {ld[STAGES-1:1], issue_load};
        rd[1] <= issue_rd;
        for (int k = 2; k <= STAGES; k++) rd[k] <= rd[k-1];
    end
`ifdef STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt <= '0;
        else if (stall && state == RUN && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule
